// File: rtl/piece_queue_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : piece_queue_pkg
//  Description : Shared piece encoding and bag helper functions for the
//                piece queue (7-bag randomizer with preview and hold).
//  Revision    : 1.0  initial release
// ============================================================================
package piece_queue_pkg;

    // Piece index as seen on every port of the queue
    typedef logic [2:0] piece_t;

    localparam piece_t PIECE_I     = 3'd0;
    localparam piece_t PIECE_J     = 3'd1;
    localparam piece_t PIECE_L     = 3'd2;
    localparam piece_t PIECE_O     = 3'd3;
    localparam piece_t PIECE_S     = 3'd4;
    localparam piece_t PIECE_T     = 3'd5;
    localparam piece_t PIECE_Z     = 3'd6;
    localparam piece_t PIECE_EMPTY = 3'd7;

    // Galois feedback mask of the 16-bit randomizer
    localparam logic [15:0] c_lfsr_taps = 16'hB400;

    // Bag with all seven pieces still available
    localparam logic [6:0] c_bag_full = 7'h7F;

    // Number of pieces still left in the bag
    function automatic logic [2:0] popcount7(input logic [6:0] mask);
        logic [2:0] cnt;
        cnt = 3'd0;
        for (int i = 0; i < 7; i++) begin
            cnt = cnt + {2'b00, mask[i]};
        end
        return cnt;
    endfunction

    // Position of the k-th set bit counting from the LSB (k=0 is the lowest);
    // EMPTY if fewer than k+1 bits are set
    function automatic piece_t kth_set_bit(input logic [6:0] mask, input logic [7:0] k);
        logic [7:0] seen;
        piece_t     res;
        seen = 8'd0;
        res  = PIECE_EMPTY;
        for (int i = 0; i < 7; i++) begin
            if (mask[i]) begin
                if ((seen == k) && (res == PIECE_EMPTY)) begin
                    res = piece_t'(i);
                end
                seen = seen + 8'd1;
            end
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/piece_queue_bag_randomizer.sv
`default_nettype none
// ============================================================================
//  Module      : bag_randomizer
//  Description : Free-running 16-bit Galois LFSR plus a 7-bag remaining mask.
//                draw_idx is the piece a draw would take this cycle; asserting
//                draw_en removes it from the bag (refilling when emptied).
//  Revision    : 1.0  initial release
// ============================================================================
module bag_randomizer
    import piece_queue_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       draw_en,
    output logic [2:0] draw_idx
);

    // An all-zero LFSR would lock up, so a zero seed is promoted to 1
    localparam logic [15:0] c_seed = (SEED == 16'h0000) ? 16'h0001 : SEED;

    logic [15:0] r_lfsr;
    logic [6:0]  r_mask;
    logic [2:0]  w_count;
    logic [7:0]  w_k;
    piece_t      w_pick;
    logic [6:0]  w_mask_left;

    // Pick the k-th remaining piece, k = lfsr low byte mod pieces left
    always_comb begin
        w_count     = popcount7(r_mask);
        w_k         = (w_count == 3'd0) ? 8'd0 : (r_lfsr[7:0] % {5'd0, w_count});
        w_pick      = kth_set_bit(r_mask, w_k);
        w_mask_left = r_mask & ~(7'b000_0001 << w_pick);
    end

    assign draw_idx = w_pick;

    // LFSR steps every cycle out of reset, independent of draws
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lfsr <= c_seed;
        end else if (r_lfsr[0]) begin
            r_lfsr <= {1'b0, r_lfsr[15:1]} ^ c_lfsr_taps;
        end else begin
            r_lfsr <= {1'b0, r_lfsr[15:1]};
        end
    end

    // Remove the drawn piece; the draw that empties the bag refills it at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mask <= c_bag_full;
        end else if (draw_en) begin
            r_mask <= (w_mask_left == 7'h00) ? c_bag_full : w_mask_left;
        end
    end

endmodule
`default_nettype wire

// File: rtl/piece_queue.sv
`default_nettype none
// ============================================================================
//  Module      : piece_queue
//  Description : Next-piece queue for a falling-block game. Fills a preview
//                window from a 7-bag randomizer, then serves spawn and hold
//                requests with a one-cycle spawn_valid pulse.
//                PREVIEW_DEPTH legal range is 1..6.
//  Revision    : 1.0  initial release
// ============================================================================
module piece_queue
    import piece_queue_pkg::*;
#(
    parameter int          PREVIEW_DEPTH = 3,
    parameter logic [15:0] SEED          = 16'hACE1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         spawn_req,
    input  logic                         hold_req,
    input  logic [2:0]                   active_idx,
    output logic                         ready,
    output logic                         spawn_valid,
    output logic [2:0]                   spawn_idx,
    output logic [PREVIEW_DEPTH*3-1:0]   preview,
    output logic [2:0]                   hold_idx,
    output logic                         hold_used
);

    localparam logic [0:0] c_state_fill = 1'b0;
    localparam logic [0:0] c_state_idle = 1'b1;
    localparam logic [2:0] c_last_slot  = 3'(PREVIEW_DEPTH - 1);

    logic [0:0] r_state;
    logic [2:0] r_fill_cnt;
    piece_t     r_preview [PREVIEW_DEPTH];
    piece_t     r_spawn_idx;
    logic       r_spawn_valid;
    piece_t     r_hold_idx;
    logic       r_hold_used;

    logic       w_fill;
    logic       w_idle;
    logic       w_do_spawn;
    logic       w_hold_ok;
    logic       w_hold_empty;
    logic       w_hold_swap;
    logic       w_shift;
    logic       w_draw_en;
    logic [2:0] w_draw_idx;
    piece_t     w_filled  [PREVIEW_DEPTH];
    piece_t     w_shifted [PREVIEW_DEPTH];

    bag_randomizer #(
        .SEED     (SEED)
    ) u_bag (
        .clk      (clk),
        .rst      (rst),
        .draw_en  (w_draw_en),
        .draw_idx (w_draw_idx)
    );

    // Request decode: spawn beats hold, hold needs an unused hold and a real piece
    always_comb begin
        w_fill       = (r_state == c_state_fill);
        w_idle       = (r_state == c_state_idle);
        w_do_spawn   = w_idle & spawn_req;
        w_hold_ok    = w_idle & ~spawn_req & hold_req & ~r_hold_used &
                       (active_idx != PIECE_EMPTY);
        w_hold_empty = w_hold_ok & (r_hold_idx == PIECE_EMPTY);
        w_hold_swap  = w_hold_ok & ~w_hold_empty;
        // A swap returns the held piece and leaves the preview/bag alone
        w_shift      = w_do_spawn | w_hold_empty;
        w_draw_en    = w_fill | w_shift;
    end

    // Candidate preview contents for a fill step and for a shift step
    always_comb begin
        w_filled  = r_preview;
        w_shifted = r_preview;
        for (int i = 0; i < PREVIEW_DEPTH; i++) begin
            if (r_fill_cnt == 3'(i)) begin
                w_filled[i] = w_draw_idx;
            end
        end
        for (int i = 0; i < PREVIEW_DEPTH - 1; i++) begin
            w_shifted[i] = r_preview[i + 1];
        end
        w_shifted[PREVIEW_DEPTH - 1] = w_draw_idx;
    end

    // Fill one slot per cycle, then serve requests forever
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_state_fill;
            r_fill_cnt <= 3'd0;
        end else if (w_fill) begin
            r_fill_cnt <= r_fill_cnt + 3'd1;
            if (r_fill_cnt == c_last_slot) begin
                r_state <= c_state_idle;
            end
        end
    end

    // Preview window: filled bottom-up, then shifted toward entry 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < PREVIEW_DEPTH; i++) begin
                r_preview[i] <= PIECE_EMPTY;
            end
        end else if (w_fill) begin
            r_preview <= w_filled;
        end else if (w_shift) begin
            r_preview <= w_shifted;
        end
    end

    // Spawn pulse, spawned piece and hold slot bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_spawn_valid <= 1'b0;
            r_spawn_idx   <= PIECE_EMPTY;
            r_hold_idx    <= PIECE_EMPTY;
            r_hold_used   <= 1'b0;
        end else begin
            r_spawn_valid <= w_do_spawn | w_hold_ok;
            if (w_shift) begin
                r_spawn_idx <= r_preview[0];
            end else if (w_hold_swap) begin
                r_spawn_idx <= r_hold_idx;
            end
            if (w_do_spawn) begin
                r_hold_used <= 1'b0;
            end else if (w_hold_ok) begin
                r_hold_used <= 1'b1;
                r_hold_idx  <= active_idx;
            end
        end
    end

    // Flatten the preview window, entry 0 in the low bits
    always_comb begin
        preview = '0;
        for (int i = 0; i < PREVIEW_DEPTH; i++) begin
            preview[3*i +: 3] = r_preview[i];
        end
    end

    assign ready       = w_idle;
    assign spawn_valid = r_spawn_valid;
    assign spawn_idx   = r_spawn_idx;
    assign hold_idx    = r_hold_idx;
    assign hold_used   = r_hold_used;

endmodule
`default_nettype wire

// File: doc/piece_queue.md
PIECE_QUEUE -- requirements
Module: piece_queue

Interface
REQ-001 Parameter PREVIEW_DEPTH, default 3, number of upcoming pieces exposed; legal range 1..6.
REQ-002 Parameter SEED, default 16'hACE1, LFSR reset value; SEED=0 SHALL be replaced by 16'h0001.
REQ-003 clk  in  1  system clock; one clock, all state on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 spawn_req  in  1  single-cycle request for the next piece.
REQ-006 hold_req  in  1  single-cycle request to swap the active piece with the hold slot.
REQ-007 active_idx  in  3  index of the piece currently in play, sampled with hold_req.
REQ-008 ready  out  1  queue full; requests accepted only when high.
REQ-009 spawn_valid  out  1  one-cycle pulse: spawn_idx holds a new piece to place.
REQ-010 spawn_idx  out  3  piece to spawn; valid while spawn_valid=1.
REQ-011 preview  out  PREVIEW_DEPTH x 3  upcoming pieces; entry 0 is dealt next.
REQ-012 hold_idx  out  3  held piece; 7 (EMPTY) when none.
REQ-013 hold_used  out  1  hold already used for the current piece.

Function
REQ-014 Piece encoding SHALL be I=0, J=1, L=2, O=3, S=4, T=5, Z=6, EMPTY=7.
REQ-015 16-bit Galois LFSR, taps mask 16'hB400, SHALL advance every cycle rst is low.
REQ-016 7-bag: 7-bit remaining mask; each draw SHALL take the k-th set bit (LSB first), k = lfsr[7:0] mod popcount(mask), and clear it.
REQ-017 When a draw clears the last bit, the mask SHALL reload to 7'h7F in the same cycle; every aligned group of 7 draws is a permutation of 0..6.
REQ-018 States: FILL, IDLE. FILL performs one draw per cycle into the lowest empty preview slot; after PREVIEW_DEPTH draws, next state IDLE.
REQ-019 ready SHALL be 1 exactly in IDLE.
REQ-020 Spawn (IDLE, spawn_req=1): next cycle spawn_idx=old preview[0], spawn_valid=1, preview shifts down one, new draw enters preview[PREVIEW_DEPTH-1], hold_used=0.
REQ-021 Hold into empty slot (IDLE, hold_req=1, hold_used=0, hold_idx=7, active_idx<7): hold_idx<=active_idx, then proceeds as REQ-020 except hold_used<=1.
REQ-022 Hold swap (IDLE, hold_req=1, hold_used=0, hold_idx<7, active_idx<7): next cycle spawn_idx=old hold_idx, spawn_valid=1, hold_idx=active_idx, hold_used=1; preview and bag unchanged.
REQ-023 hold_req SHALL be ignored when hold_used=1 or active_idx=7.
REQ-024 spawn_req and hold_req in the same cycle: spawn wins, hold dropped.
REQ-025 Requests while ready=0 SHALL be ignored, not queued.
REQ-026 spawn_valid SHALL be 0 on every cycle not following an accepted request; latency request->spawn_valid is exactly 1 cycle; back-to-back requests accepted every cycle.

Reset
REQ-027 On rst: state FILL, lfsr=SEED, mask=7'h7F, all preview=7, spawn_idx=7, spawn_valid=0, hold_idx=7, hold_used=0, ready=0, asynchronously.
REQ-028 rst mid-FILL or mid-game SHALL abandon all state; identical SEED and stimulus after release SHALL reproduce an identical piece sequence.

Structure
REQ-029 Piece index typedef and PIECE_EMPTY constant SHALL live in the shared global package, not locally.
REQ-030 LFSR, bag mask and k-th-set-bit selection SHALL be one sub-module, bag_randomizer, exposing draw_en and draw_idx.

Verification
REQ-031 Release reset, PREVIEW_DEPTH=3 -> ready=1 on cycle 4; preview entries <7 and pairwise distinct.
REQ-032 Spawn every cycle for 21 cycles -> first 21 dealt pieces (fills + spawns, in order) form three permutations of 0..6.
REQ-033 Hold empty, active_idx=5 -> hold_idx=5, spawn_idx=old preview[0], hold_used=1; repeated hold_req -> no spawn_valid, no change.
REQ-034 After a spawn (hold_used=0), hold_idx=5, hold_req with active_idx=2 -> spawn_idx=5, hold_idx=2, preview unchanged.
REQ-035 spawn_req+hold_req same cycle -> spawn only, hold_idx unchanged; requests during FILL -> no spawn_valid.
REQ-036 rst pulse mid-FILL -> all outputs at reset values within the same cycle; rerun matches first sequence; repeat REQ-031/032 with PREVIEW_DEPTH=1 and 6.
